multi_tick_gen: RTL and testbench
=================================

MULTI_TICK_GEN -- requirements
Module: multi_tick_gen

Interface
- REQ-001: Parameter NUM_CH, default 4: number of independent tick channels (1..16).
- REQ-002: Parameter DIV_W, default 32: divisor and counter width in bits.
- REQ-003: Parameter DIV_INIT, default 25000: divisor loaded into every channel at reset (≥1).
- REQ-004: clk  input  1  rising-edge clock for all logic.
- REQ-005: rst  input  1  reset, synchronous, active-high.
- REQ-006: ch_en  input  NUM_CH  per-channel run enable.
- REQ-007: sync  input  1  single-cycle pulse that restarts all channel counters in phase.
- REQ-008: cfg_valid  input  1  divisor update request.
- REQ-009: cfg_ch  input  max(1,$clog2(NUM_CH))  target channel of the update.
- REQ-010: cfg_div  input  DIV_W  new divisor, in clk cycles per tick.
- REQ-011: cfg_ready  output  1  update slot free; transfer occurs when cfg_valid and cfg_ready are both high.
- REQ-012: cfg_err  output  1  one-cycle pulse on a rejected update.
- REQ-013: tick  output  NUM_CH  one-cycle registered tick pulse per channel.
- REQ-014: tick_count  output  NUM_CH*16  per-channel 16-bit tick counters (see Configuration).

Function
- REQ-015: Each channel SHALL hold cnt[DIV_W-1:0] and div[DIV_W-1:0]; with ch_en high, cnt increments each cycle and wraps to 0 after div-1.
- REQ-016: tick[i] SHALL be high for exactly the cycle after cnt[i] equals div[i]-1 with ch_en[i] high, giving period div[i] cycles; div=1 gives tick high every cycle.
- REQ-017: With ch_en[i] low, cnt[i] SHALL be held at 0 and tick[i] forced to 0 on the next cycle; after ch_en[i] rises, the first tick SHALL occur div[i] cycles later.
- REQ-018: sync SHALL force every cnt to 0 in the same cycle and SHALL suppress the wrap for that cycle; sync overrides a coincident wrap.
- REQ-019: An accepted update with cfg_div ≥ 1 and cfg_ch < NUM_CH SHALL be stored in a single pending slot, and cfg_ready SHALL drop the following cycle.
- REQ-020: The pending divisor SHALL be applied to div[cfg_ch] on the target channel's next wrap, or on sync, or on any cycle the target channel is disabled. cnt SHALL restart at 0 and cfg_ready SHALL return high the next cycle.
- REQ-021: An update with cfg_div = 0 or cfg_ch ≥ NUM_CH SHALL be accepted, discarded, and SHALL pulse cfg_err one cycle later; cfg_ready stays high.
- REQ-022: A tick on the applying wrap SHALL still be emitted under the old divisor; ticks never glitch or double.
- REQ-023: All channel counters SHALL run concurrently and independently; arithmetic is unsigned, modulo 2^DIV_W.

Reset
- REQ-024: On rst: every cnt = 0, every div = DIV_INIT, pending slot empty, tick = 0, cfg_err = 0, cfg_ready = 1, tick_count = 0.
- REQ-025: rst asserted mid-operation SHALL discard any pending update without applying it; rst overrides sync and cfg_valid.

Configuration
- REQ-026: Macro MULTI_TICK_GEN_COUNT_EN defined: tick_count[16i+15:16i] SHALL increment by 1 on each tick[i], wrap from 0xFFFF to 0, and clear on rst.
- REQ-027: Macro undefined: tick_count SHALL be constant 0 and no counter logic SHALL be synthesised.

Verification (NUM_CH=4, DIV_W=16, DIV_INIT=4)
- REQ-028: Release rst, ch_en=4'b1111 -> each tick[i] pulses every 4 cycles, all in phase; first pulse 4 cycles after enable.
- REQ-029: Write cfg_ch=1, cfg_div=7 mid-period -> cfg_ready low until ch1 wraps; ch1's current period stays 4; afterwards its period is 7; other channels unaffected.
- REQ-030: cfg_div=0 then cfg_ch=5 with NUM_CH=4 (cfg_ch width 2, so drive NUM_CH=5 variant or value 3 valid) -> cfg_err pulses once per bad write; divisors unchanged.
- REQ-031: Set ch0 div=3, ch2 div=5, free run, pulse sync -> both counters restart; next ticks are exactly 3 and 5 cycles after sync, with no tick in the sync cycle.
- REQ-032: Assert rst while an update is pending -> div stays DIV_INIT, cfg_ready=1 one cycle after rst, tick all 0.
- REQ-033: MULTI_TICK_GEN_COUNT_EN defined, div=1, 65537 cycles -> tick_count[15:0] = 1 (wrapped); with the macro undefined it stays 0.

Source files
------------

// File: rtl/multi_tick_gen.sv
// multi_tick_gen: NUM_CH independent programmable tick generators with
// in-phase sync and a single-slot valid/ready divisor update path.
// Ports: clk, rst (sync, active-high), ch_en, sync, cfg_valid/cfg_ch/cfg_div,
//   cfg_ready, cfg_err, tick (per channel), tick_count (16 bits per channel).
// Build option: define MULTI_TICK_GEN_COUNT_EN to enable the per-channel
//   tick counters; otherwise tick_count is tied to 0.
module multi_tick_gen #(
    parameter int NUM_CH   = 4,
    parameter int DIV_W    = 32,
    parameter int DIV_INIT = 25000,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CH-1:0]    ch_en,
    input  logic                 sync,
    input  logic                 cfg_valid,
    input  logic [CH_W-1:0]      cfg_ch,
    input  logic [DIV_W-1:0]     cfg_div,
    output logic                 cfg_ready,
    output logic                 cfg_err,
    output logic [NUM_CH-1:0]    tick,
    output logic [NUM_CH*16-1:0] tick_count
);

    localparam logic [DIV_W-1:0] DIV_RST  = DIV_W'(DIV_INIT);
    localparam logic [DIV_W-1:0] ONE      = DIV_W'(1);
    localparam logic [CH_W:0]    NUM_CH_L = (CH_W+1)'(NUM_CH);

    logic [NUM_CH-1:0][DIV_W-1:0] cnt_q, cnt_d;
    logic [NUM_CH-1:0][DIV_W-1:0] div_q, div_d;
    logic [NUM_CH-1:0]            tick_q, tick_d;
    logic                         pend_vld_q, pend_vld_d;
    logic [CH_W-1:0]              pend_ch_q, pend_ch_d;
    logic [DIV_W-1:0]             pend_div_q, pend_div_d;
    logic                         cfg_err_q, cfg_err_d;

    logic [NUM_CH-1:0]            wrap;
    logic [NUM_CH-1:0]            apply;
    logic                         cfg_bad;

    always_comb begin
        wrap  = '0;
        apply = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wrap[i]  = ch_en[i] && (cnt_q[i] == div_q[i] - ONE);
            // Pending divisor lands at a point where the counter restarts anyway.
            apply[i] = pend_vld_q && (pend_ch_q == CH_W'(i))
                       && (wrap[i] || sync || !ch_en[i]);
        end
    end

    assign cfg_bad = (cfg_div == '0) || ({1'b0, cfg_ch} >= NUM_CH_L);

    always_comb begin
        cnt_d      = cnt_q;
        div_d      = div_q;
        tick_d     = '0;
        pend_vld_d = pend_vld_q;
        pend_ch_d  = pend_ch_q;
        pend_div_d = pend_div_q;
        cfg_err_d  = 1'b0;

        for (int i = 0; i < NUM_CH; i++) begin
            if (!ch_en[i] || sync || wrap[i]) begin
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + ONE;
            end
            // Sync wins over a coincident wrap: no tick that cycle.
            tick_d[i] = wrap[i] && !sync;
            if (apply[i]) begin
                div_d[i] = pend_div_q;
                cnt_d[i] = '0;
            end
        end

        if (|apply) begin
            pend_vld_d = 1'b0;
        end

        if (cfg_valid && !pend_vld_q) begin
            if (cfg_bad) begin
                cfg_err_d = 1'b1;
            end else begin
                pend_vld_d = 1'b1;
                pend_ch_d  = cfg_ch;
                pend_div_d = cfg_div;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            div_q      <= {NUM_CH{DIV_RST}};
            tick_q     <= '0;
            pend_vld_q <= 1'b0;
            pend_ch_q  <= '0;
            pend_div_q <= '0;
            cfg_err_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            tick_q     <= tick_d;
            pend_vld_q <= pend_vld_d;
            pend_ch_q  <= pend_ch_d;
            pend_div_q <= pend_div_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    assign cfg_ready = !pend_vld_q;
    assign cfg_err   = cfg_err_q;
    assign tick      = tick_q;

`ifdef MULTI_TICK_GEN_COUNT_EN
    logic [NUM_CH-1:0][15:0] tcnt_q, tcnt_d;

    // Counts alongside the registered tick so tick_count includes the
    // pulse currently visible on tick.
    always_comb begin
        tcnt_d = tcnt_q;
        for (int i = 0; i < NUM_CH; i++) begin
            tcnt_d[i] = tcnt_q[i] + {15'd0, tick_d[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt_q <= '0;
        end else begin
            tcnt_q <= tcnt_d;
        end
    end

    assign tick_count = tcnt_q;
`else
    assign tick_count = '0;
`endif

endmodule

// File: tb/tb_multi_tick_gen.sv
// tb_multi_tick_gen: directed self-checking bench for multi_tick_gen
// with NUM_CH=4, DIV_W=16, DIV_INIT=4.
module tb_multi_tick_gen;

    localparam int NCH = 4;
    localparam int DW  = 16;
    localparam int DI  = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NCH-1:0]  ch_en = '0;
    logic            sync = 1'b0;
    logic            cfg_valid = 1'b0;
    logic [1:0]      cfg_ch = '0;
    logic [DW-1:0]   cfg_div = '0;
    logic            cfg_ready;
    logic            cfg_err;
    logic [NCH-1:0]  tick;
    logic [NCH*16-1:0] tick_count;

    int n_run  = 0;
    int n_fail = 0;
    int k;
    int per_m[NCH];
    int ref_m[NCH];

    always #5 clk = ~clk;

    multi_tick_gen #(
        .NUM_CH  (NCH),
        .DIV_W   (DW),
        .DIV_INIT(DI)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ch_en     (ch_en),
        .sync      (sync),
        .cfg_valid (cfg_valid),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .tick      (tick),
        .tick_count(tick_count)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NCH-1:0] exp_tick(input int kk);
        logic [NCH-1:0] e;
        e = '0;
        for (int i = 0; i < NCH; i++) begin
            e[i] = (kk >= ref_m[i]) && (((kk - ref_m[i]) % per_m[i]) == 0);
        end
        return e;
    endfunction

    task automatic tstep();
        step();
        k++;
        check($sformatf("tick@%0d", k), 64'(tick), 64'(exp_tick(k)));
    endtask

    task automatic set_model(input int r0, r1, r2, r3, p0, p1, p2, p3);
        ref_m[0] = r0; ref_m[1] = r1; ref_m[2] = r2; ref_m[3] = r3;
        per_m[0] = p0; per_m[1] = p1; per_m[2] = p2; per_m[3] = p3;
    endtask

    task automatic cfg_write(input logic [1:0] ch, input logic [DW-1:0] dv);
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_div   = dv;
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 20 && !cfg_ready; i++) step();
        check("ready_wait", 64'(cfg_ready), 64'd1);
    endtask

    initial begin
        // reset state
        step();
        step();
        check("rst_tick", 64'(tick), 64'd0);
        check("rst_ready", 64'(cfg_ready), 64'd1);
        check("rst_err", 64'(cfg_err), 64'd0);
        check("rst_tcnt", tick_count, 64'd0);

        // free run, all in phase, period 4
        rst   = 1'b0;
        ch_en = 4'b1111;
        k     = 0;
        set_model(4, 4, 4, 4, 4, 4, 4, 4);
        repeat (9) tstep();

        // ch1 -> 7 mid-period
        cfg_valid = 1'b1;
        cfg_ch    = 2'd1;
        cfg_div   = 16'd7;
        tstep();
        cfg_valid = 1'b0;
        check("upd_rdy0", 64'(cfg_ready), 64'd0);
        tstep();
        check("upd_rdy1", 64'(cfg_ready), 64'd0);
        tstep();
        set_model(4, 19, 4, 4, 4, 7, 4, 4);
        check("upd_rdy_back", 64'(cfg_ready), 64'd1);
        repeat (14) tstep();

        // rejected writes
        cfg_valid = 1'b1;
        cfg_ch    = 2'd2;
        cfg_div   = 16'd0;
        tstep();
        cfg_valid = 1'b0;
        check("err_pulse1", 64'(cfg_err), 64'd1);
        check("err_rdy", 64'(cfg_ready), 64'd1);
        tstep();
        check("err_clr1", 64'(cfg_err), 64'd0);
        cfg_valid = 1'b1;
        cfg_ch    = 2'd0;
        cfg_div   = 16'd0;
        tstep();
        cfg_valid = 1'b0;
        check("err_pulse2", 64'(cfg_err), 64'd1);
        tstep();
        check("err_clr2", 64'(cfg_err), 64'd0);
        repeat (10) tstep();

        // sync with ch0=3, ch2=5
        cfg_write(2'd0, 16'd3);
        wait_ready();
        cfg_write(2'd2, 16'd5);
        wait_ready();
        repeat (3) step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        check("sync_tick", 64'(tick), 64'd0);
        k = 0;
        set_model(3, 7, 5, 4, 3, 7, 5, 4);
        repeat (15) tstep();

        // update applied immediately on a disabled channel
        ch_en = 4'b0111;
        step();
        step();
        cfg_write(2'd3, 16'd2);
        check("dis_rdy0", 64'(cfg_ready), 64'd0);
        step();
        check("dis_rdy1", 64'(cfg_ready), 64'd1);
        check("dis_tick", 64'(tick[3]), 64'd0);
        ch_en = 4'b1111;
        step();
        check("dis_first0", 64'(tick[3]), 64'd0);
        step();
        check("dis_first1", 64'(tick[3]), 64'd1);

        // reset while an update is pending
        cfg_write(2'd1, 16'd9);
        check("pend_rdy", 64'(cfg_ready), 64'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst2_ready", 64'(cfg_ready), 64'd1);
        check("rst2_tick", 64'(tick), 64'd0);
        check("rst2_err", 64'(cfg_err), 64'd0);
        k = 0;
        set_model(4, 4, 4, 4, 4, 4, 4, 4);
        repeat (8) tstep();

`ifdef MULTI_TICK_GEN_COUNT_EN
        check("tcnt_two", tick_count, {4{16'd2}});
        ch_en = 4'b1110;
        cfg_write(2'd0, 16'd1);
        wait_ready();
        check("tcnt_pre", 64'(tick_count[15:0]), 64'd2);
        ch_en = 4'b1111;
        repeat (65535) step();
        check("tcnt_wrap", 64'(tick_count[15:0]), 64'd1);
`else
        check("tcnt_zero", tick_count, 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
